// File: rtl/midi_byte_rx.sv
// MIDI serial receiver: synchronises the raw opto-isolated line, rejects short
// start glitches, de-serialises 8N1 frames and flags bad stop bits.
module midi_byte_rx #(
    parameter int CLKS_PER_BIT = 512,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_in,
    output logic [7:0] uart_data,
    output logic       uart_data_rdy,
    output logic       uart_frame_err,
    output logic       uart_busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       rdy_q, rdy_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       sync1_q, sync2_q, s_prev_q;
    logic       s;
    logic       fall;
    logic       take_bit;

    assign s    = sync2_q;
    assign fall = s_prev_q & ~s;

    // Each shift-register bit loads only when its own index is being sampled.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_d[gi] = (take_bit && (bit_idx_q == 3'(gi))) ? s : shift_q[gi];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        take_bit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (fall) begin
                    state_d = S_START;
                end
            end

            // Half a bit in: a line that is high again was only a glitch.
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    take_bit  = 1'b1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Leaving at mid-stop keeps a back-to-back start edge detectable.
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (s) begin
                        data_d  = shift_q;
                        rdy_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_BREAK_WAIT: begin
                cnt_d = '0;
                if (s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            s_prev_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            sync1_q   <= midi_in;
            sync2_q   <= sync1_q;
            s_prev_q  <= sync2_q;
        end
    end

    assign uart_data      = data_q;
    assign uart_data_rdy  = rdy_q;
    assign uart_frame_err = err_q;
    assign uart_busy      = busy_q;

endmodule

// File: tb/tb_midi_byte_rx.sv
// Directed bench for midi_byte_rx at 16 clocks per bit.
module tb_midi_byte_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       midi_in = 1'b1;
    logic [7:0] uart_data;
    logic       uart_data_rdy;
    logic       uart_frame_err;
    logic       uart_busy;

    midi_byte_rx #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .midi_in       (midi_in),
        .uart_data     (uart_data),
        .uart_data_rdy (uart_data_rdy),
        .uart_frame_err(uart_frame_err),
        .uart_busy     (uart_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder sampled on the falling edge.
    int         rdy_cnt = 0;
    int         err_cnt = 0;
    int         overlap_cnt = 0;
    int         wide_cnt = 0;
    logic [7:0] rdy_data[$];
    int         rdy_cyc[$];
    logic       rdy_prev = 1'b0;
    logic       err_prev = 1'b0;

    always @(negedge clk) begin
        if (uart_data_rdy === 1'b1) begin
            rdy_cnt++;
            rdy_data.push_back(uart_data);
            rdy_cyc.push_back(cyc);
            $display("[TB] rdy   cyc=%0d data=0x%02h", cyc, uart_data);
        end
        if (uart_frame_err === 1'b1) begin
            err_cnt++;
            $display("[TB] err   cyc=%0d", cyc);
        end
        if (uart_data_rdy === 1'b1 && uart_frame_err === 1'b1) overlap_cnt++;
        if ((uart_data_rdy === 1'b1 && rdy_prev) || (uart_frame_err === 1'b1 && err_prev)) wide_cnt++;
        rdy_prev = (uart_data_rdy === 1'b1);
        err_prev = (uart_frame_err === 1'b1);
    end

    task automatic clear_mon();
        rdy_cnt = 0;
        err_cnt = 0;
        rdy_data.delete();
        rdy_cyc.delete();
    endtask

    task automatic drive(input logic v, input int n);
        midi_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        $display("[TB] send  cyc=%0d byte=0x%02h stop=%0b", cyc, d, stop_bit);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
        drive(stop_bit, CPB);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        midi_in = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (uart_data !== 8'h00 || uart_data_rdy !== 1'b0 || uart_frame_err !== 1'b0 || uart_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_state: data=%h rdy=%b err=%b busy=%b, required 00/0/0/0",
                     uart_data, uart_data_rdy, uart_frame_err, uart_busy);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        exp_b[0] = 8'h90;
        exp_b[1] = 8'h3C;
        exp_b[2] = 8'h64;
        clear_mon();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        drive(1'b1, 2 * CPB);
        tests++;
        if (rdy_cnt !== 3) begin
            fails++;
            $display("[TB] FAIL b2b_rdy_count: got %0d, required 3", rdy_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= rdy_data.size()) begin
                fails++;
                $display("[TB] FAIL b2b_data[%0d]: missing, required 0x%02h", i, exp_b[i]);
            end else if (rdy_data[i] !== exp_b[i]) begin
                fails++;
                $display("[TB] FAIL b2b_data[%0d]: got 0x%02h, required 0x%02h", i, rdy_data[i], exp_b[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            tests++;
            if (i >= rdy_cyc.size()) begin
                fails++;
                $display("[TB] FAIL b2b_spacing[%0d]: pulse missing, required 160", i);
            end else if (rdy_cyc[i] - rdy_cyc[i-1] !== 160) begin
                fails++;
                $display("[TB] FAIL b2b_spacing[%0d]: got %0d, required 160", i, rdy_cyc[i] - rdy_cyc[i-1]);
            end
        end
        tests++;
        if (err_cnt !== 0) begin
            fails++;
            $display("[TB] FAIL b2b_no_err: got %0d err pulses, required 0", err_cnt);
        end
    endtask

    task automatic test_glitch();
        int busy_cycles;
        clear_mon();
        busy_cycles = 0;
        $display("[TB] glitch cyc=%0d low for 5 cycles", cyc);
        midi_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (uart_busy === 1'b1) busy_cycles++;
        end
        midi_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uart_busy === 1'b1) busy_cycles++;
        end
        tests++;
        if (busy_cycles < 1 || busy_cycles > 11) begin
            fails++;
            $display("[TB] FAIL glitch_busy_len: got %0d cycles, required 1..11", busy_cycles);
        end
        tests++;
        if (uart_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL glitch_busy_end: got %b, required 0", uart_busy);
        end
        tests++;
        if (rdy_cnt !== 0 || err_cnt !== 0) begin
            fails++;
            $display("[TB] FAIL glitch_no_flags: rdy=%0d err=%0d, required 0/0", rdy_cnt, err_cnt);
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'hF8, 1'b0);
        drive(1'b0, 50);
        tests++;
        if (uart_busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL break_busy: got %b, required 1", uart_busy);
        end
        drive(1'b0, 50);
        drive(1'b1, 3 * CPB);
        tests++;
        if (err_cnt !== 1) begin
            fails++;
            $display("[TB] FAIL frame_err_count: got %0d, required 1", err_cnt);
        end
        tests++;
        if (rdy_cnt !== 0) begin
            fails++;
            $display("[TB] FAIL frame_err_no_rdy: got %0d, required 0", rdy_cnt);
        end
        tests++;
        if (uart_data !== 8'h64) begin
            fails++;
            $display("[TB] FAIL frame_err_data_hold: got 0x%02h, required 0x64", uart_data);
        end
        tests++;
        if (uart_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL break_release: busy=%b, required 0", uart_busy);
        end
        clear_mon();
        send_frame(8'hFE, 1'b1);
        drive(1'b1, 2 * CPB);
        tests++;
        if (rdy_cnt !== 1 || err_cnt !== 0) begin
            fails++;
            $display("[TB] FAIL after_err_counts: rdy=%0d err=%0d, required 1/0", rdy_cnt, err_cnt);
        end
        tests++;
        if (uart_data !== 8'hFE) begin
            fails++;
            $display("[TB] FAIL after_err_data: got 0x%02h, required 0xFE", uart_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'hA5;
        clear_mon();
        $display("[TB] send  cyc=%0d byte=0xa5 (reset during bit 4)", cyc);
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(d[i], CPB);
        drive(d[4], CPB / 2);
        tests++;
        if (uart_busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midframe_busy: got %b, required 1", uart_busy);
        end
        rst = 1'b1;
        midi_in = 1'b1;
        @(negedge clk);
        tests++;
        if (uart_busy !== 1'b0 || uart_data !== 8'h00 || uart_data_rdy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midframe_reset: busy=%b data=0x%02h rdy=%b, required 0/0x00/0",
                     uart_busy, uart_data, uart_data_rdy);
        end
        rst = 1'b0;
        drive(1'b1, 12 * CPB);
        tests++;
        if (rdy_cnt !== 0 || err_cnt !== 0) begin
            fails++;
            $display("[TB] FAIL midframe_no_flags: rdy=%0d err=%0d, required 0/0", rdy_cnt, err_cnt);
        end
        clear_mon();
        send_frame(8'h55, 1'b1);
        drive(1'b1, 2 * CPB);
        tests++;
        if (rdy_cnt !== 1 || uart_data !== 8'h55) begin
            fails++;
            $display("[TB] FAIL post_reset_rx: rdy=%0d data=0x%02h, required 1/0x55", rdy_cnt, uart_data);
        end
    endtask

    task automatic test_latency_jitter();
        int start_cyc;
        int lat;
        clear_mon();
        start_cyc = cyc;
        $display("[TB] send  cyc=%0d byte=0x01 with jittered edges", cyc);
        // Edges at 0, 16+3, 32-3, 144+3: start, b0=1, b1..b7=0, stop.
        drive(1'b0, 19);
        drive(1'b1, 10);
        drive(1'b0, 118);
        drive(1'b1, 3 * CPB);
        tests++;
        if (rdy_cnt !== 1 || err_cnt !== 0) begin
            fails++;
            $display("[TB] FAIL jitter_counts: rdy=%0d err=%0d, required 1/0", rdy_cnt, err_cnt);
        end
        tests++;
        if (uart_data !== 8'h01) begin
            fails++;
            $display("[TB] FAIL jitter_data: got 0x%02h, required 0x01", uart_data);
        end
        tests++;
        if (rdy_cyc.size() < 1) begin
            fails++;
            $display("[TB] FAIL latency: no rdy pulse, required 155+-1");
        end else begin
            lat = rdy_cyc[0] - start_cyc;
            if (lat < 154 || lat > 156) begin
                fails++;
                $display("[TB] FAIL latency: got %0d, required 155+-1", lat);
            end
        end
    endtask

    task automatic test_pulse_shape();
        tests++;
        if (overlap_cnt !== 0) begin
            fails++;
            $display("[TB] FAIL rdy_err_overlap: got %0d, required 0", overlap_cnt);
        end
        tests++;
        if (wide_cnt !== 0) begin
            fails++;
            $display("[TB] FAIL pulse_width: got %0d wide pulses, required 0", wide_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_latency_jitter();
        test_pulse_shape();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/midi_byte_rx.md
Name: midi_byte_rx

Overview:
Serial front end for the MIDI input path. Converts the raw opto-isolated MIDI line (31250 baud, 8N1, idle high) into parallel bytes with a one-cycle ready strobe. The MIDI message parser consumes these bytes directly. Adds input synchronisation, start-bit glitch rejection and framing-error reporting so that the parser sees only validated bytes.

Parameters:
CLKS_PER_BIT, 512, number of clk cycles per MIDI bit (16 MHz / 31250). Must be even and >= 4.
CNT_W, 10, width of the bit-timing counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
midi_in  input  1  asynchronous serial MIDI line; idle = 1.
uart_data  output  8  last correctly framed byte, LSB received first.
uart_data_rdy  output  1  single-cycle pulse: uart_data is valid and new.
uart_frame_err  output  1  single-cycle pulse: stop bit was sampled low.
uart_busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. On rst: state=IDLE, counter=0, bit index=0, shift register=0, uart_data=8'h00, uart_data_rdy=0, uart_frame_err=0, uart_busy=0, both synchroniser flops=1, previous-sample flop=1.
- Reset mid-frame abandons the frame immediately. No rdy or err pulse is produced, and uart_data keeps its reset value of 0.
- Input path: 2-flop synchroniser feeds s (the synchronised line). A further flop holds s_prev. Falling edge = s_prev==1 && s==0.
- States:
  - IDLE: on a falling edge, go to START with counter=0. Otherwise stay in IDLE.
  - START: counter increments every cycle. At counter==CLKS_PER_BIT/2-1, sample s. If s==0, go to DATA with counter=0 and bit index=0. If s==1, treat it as a glitch and return to IDLE; no flags are raised.
  - DATA: at counter==CLKS_PER_BIT-1, shift s into the shift register at position bit index (LSB first), set counter=0 and increment bit index. When the bit at index 7 is taken, go to STOP. Otherwise the counter increments every cycle.
  - STOP: at counter==CLKS_PER_BIT-1, sample s.
    - If s==1: uart_data <= shift register, uart_data_rdy=1 for exactly the next cycle, go to IDLE.
    - If s==0: uart_frame_err=1 for exactly the next cycle, uart_data unchanged, go to BREAK_WAIT.
  - BREAK_WAIT: stay until s==1, then go to IDLE. A held-low line (break) produces exactly one err pulse, never repeated pulses.
- All samples are taken at mid-bit, because START consumes half a bit period.
- Back-to-back frames: a start edge arriving in the cycle after leaving STOP must be detected. IDLE is re-entered at mid-stop, while the line is still high.
- Latency: uart_data_rdy rises 9.5*CLKS_PER_BIT + 3 cycles after the first midi_in low cycle, tolerance ±1.
- uart_data_rdy and uart_frame_err are never high in the same cycle.
- uart_data is stable between rdy pulses.
- Counter never exceeds CLKS_PER_BIT-1.
- No flow control: the consumer must accept uart_data_rdy in the cycle it is asserted.

Test Plan:
1. CLKS_PER_BIT=16. rst for 3 cycles, then send 0x90, 0x3C, 0x64 back-to-back, 1 stop bit each. Expect three single-cycle rdy pulses with uart_data = 0x90, 0x3C, 0x64. Expect rdy pulses spaced exactly 160 cycles apart and no frame_err.
2. Glitch rejection: midi_in low for 5 cycles (less than 8), then high. Expect no rdy and no err, and uart_busy high for at most 8+3 cycles, then low.
3. Framing error: send 0xF8 with the stop bit driven low, then hold the line low for 100 cycles. Expect exactly one frame_err pulse and no rdy. uart_data must keep its previous value. After the line returns high, send 0xFE and expect rdy with uart_data=0xFE.
4. Reset mid-frame: assert rst during data bit 4 of 0xA5. Expect no rdy, uart_data=0x00 and uart_busy=0 the cycle after rst. A subsequent 0x55 frame must be received correctly.
5. Latency/sampling: send 0x01 with ±3-cycle jitter on each bit edge. Expect uart_data=0x01, with the rdy rising edge at 155±1 cycles after midi_in falls.
